// File: rtl/instr_decode_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode_stage_pkg
// Description : Shared opcode/ext constants, FSM state type and the R-type
//               ext legality helper for the registered decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_decode_stage_pkg;

   // Major opcode (instr[15:12])
   localparam logic [3:0] OP_RTYPE = 4'h0;
   localparam logic [3:0] OP_ANDI  = 4'h1;
   localparam logic [3:0] OP_ORI   = 4'h2;
   localparam logic [3:0] OP_XORI  = 4'h3;
   localparam logic [3:0] OP_MEM   = 4'h4;
   localparam logic [3:0] OP_ADDI  = 4'h5;
   localparam logic [3:0] OP_SHIFT = 4'h8;
   localparam logic [3:0] OP_SUBI  = 4'h9;
   localparam logic [3:0] OP_CMPI  = 4'hB;
   localparam logic [3:0] OP_MOVI  = 4'hD;
   localparam logic [3:0] OP_LUI   = 4'hF;

   // Extended opcode (instr[7:4]) for memory and shift groups
   localparam logic [3:0] EXT_LOAD  = 4'h0;
   localparam logic [3:0] EXT_STORE = 4'h4;
   localparam logic [3:0] EXT_LSH   = 4'h4;
   localparam logic [3:0] EXT_ASH   = 4'h6;
   localparam logic [3:0] EXT_RSH   = 4'hF;

   // Extended opcode for the R-type group
   localparam logic [3:0] EXT_NOP  = 4'h0;
   localparam logic [3:0] EXT_AND  = 4'h1;
   localparam logic [3:0] EXT_OR   = 4'h2;
   localparam logic [3:0] EXT_XOR  = 4'h3;
   localparam logic [3:0] EXT_ADD  = 4'h5;
   localparam logic [3:0] EXT_ADDU = 4'h6;
   localparam logic [3:0] EXT_ADDC = 4'h7;
   localparam logic [3:0] EXT_SUB  = 4'h9;
   localparam logic [3:0] EXT_SUBC = 4'hA;
   localparam logic [3:0] EXT_CMP  = 4'hB;
   localparam logic [3:0] EXT_MOV  = 4'hD;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      STALL = 2'd2
   } state_t;

   function automatic logic rtype_ext_legal(input logic [3:0] ext);
      logic v_ok;
      case (ext)
         EXT_NOP, EXT_AND, EXT_OR, EXT_XOR, EXT_ADD, EXT_ADDU,
         EXT_ADDC, EXT_SUB, EXT_SUBC, EXT_CMP, EXT_MOV: v_ok = 1'b1;
         default:                                         v_ok = 1'b0;
      endcase
      return v_ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/instr_decode_comb.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode_comb
// Description : Purely combinational decode of one 16-bit instruction word
//               into the decode bundle.
// Revision    : 1.0 - initial release
// Ports       : i_instr      instruction word
//               o_op         {instr[15:12], ext or 0 for I-type}
//               o_r_dest     destination register
//               o_r_src      source register (0 for immediate forms)
//               o_imm        extended immediate (0 for register forms)
//               o_r_or_i     1 = ALU B from register, 0 = from immediate
//               o_is_load    LOAD
//               o_is_store   STORE
//               o_illegal    opcode/ext not supported
// ============================================================================
module instr_decode_comb
   import instr_decode_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic [15:0]           i_instr,
   output logic [7:0]            o_op,
   output logic [3:0]            o_r_dest,
   output logic [3:0]            o_r_src,
   output logic [DATA_WIDTH-1:0] o_imm,
   output logic                  o_r_or_i,
   output logic                  o_is_load,
   output logic                  o_is_store,
   output logic                  o_illegal
);

   logic [3:0]            w_hi;
   logic [3:0]            w_ext;
   logic [DATA_WIDTH-1:0] w_imm_zx8;
   logic [DATA_WIDTH-1:0] w_imm_sx8;
   logic [DATA_WIDTH-1:0] w_imm_lui;
   logic [DATA_WIDTH-1:0] w_imm_lshi;

   assign w_hi       = i_instr[15:12];
   assign w_ext      = i_instr[7:4];
   assign w_imm_zx8  = {{(DATA_WIDTH-8){1'b0}}, i_instr[7:0]};
   assign w_imm_sx8  = {{(DATA_WIDTH-8){i_instr[7]}}, i_instr[7:0]};
   // Shifting the sign-extended byte left by 8 gives the sign-extended
   // {byte, 8'h00} without a zero-width replication when DATA_WIDTH is 16.
   assign w_imm_lui  = {w_imm_sx8[DATA_WIDTH-9:0], 8'h00};
   // Bit 4 carries the shift direction alongside the 4-bit amount.
   assign w_imm_lshi = {{(DATA_WIDTH-5){1'b0}}, i_instr[4:0]};

   always_comb begin
      // Register-form decode is the default; unlisted codes keep it.
      o_op       = {w_hi, w_ext};
      o_r_dest   = i_instr[11:8];
      o_r_src    = i_instr[3:0];
      o_imm      = '0;
      o_r_or_i   = 1'b1;
      o_is_load  = 1'b0;
      o_is_store = 1'b0;
      o_illegal  = 1'b0;

      case (w_hi)
         OP_RTYPE: o_illegal = ~rtype_ext_legal(w_ext);
         OP_SHIFT: begin
            if (w_ext[3:1] == 3'b000) begin
               o_r_src  = 4'h0;
               o_imm    = w_imm_lshi;
               o_r_or_i = 1'b0;
            end else if (w_ext != EXT_LSH && w_ext != EXT_ASH) begin
               o_illegal = 1'b1;
            end
         end
         OP_MEM: begin
            if (w_ext == EXT_LOAD) begin
               o_is_load = 1'b1;
            end else if (w_ext == EXT_STORE) begin
               o_is_store = 1'b1;
            end else if (w_ext != EXT_RSH) begin
               o_illegal = 1'b1;
            end
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            o_op     = {w_hi, 4'h0};
            o_r_src  = 4'h0;
            o_imm    = w_imm_zx8;
            o_r_or_i = 1'b0;
         end
         OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI: begin
            o_op     = {w_hi, 4'h0};
            o_r_src  = 4'h0;
            o_imm    = w_imm_sx8;
            o_r_or_i = 1'b0;
         end
         OP_LUI: begin
            o_op     = {w_hi, 4'h0};
            o_r_src  = 4'h0;
            o_imm    = w_imm_lui;
            o_r_or_i = 1'b0;
         end
         default: o_illegal = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode_stage
// Description : Registered valid/ready decode stage. Latches the decode
//               bundle on input transfer and holds LOAD/STORE for a
//               programmable number of stall cycles after they leave.
// Revision    : 1.0 - initial release
// Ports       : clk, reset_n          clock, async active-low reset
//               in_instr/in_valid/in_ready    upstream handshake
//               out_valid/out_ready           downstream handshake
//               op, r_dest, r_src, imm, r_or_i, is_load, is_store, illegal
//                                     registered decode bundle
// ============================================================================
module instr_decode_stage
   import instr_decode_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int MEM_STALL  = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [15:0]           in_instr,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [7:0]            op,
   output logic [3:0]            r_dest,
   output logic [3:0]            r_src,
   output logic [DATA_WIDTH-1:0] imm,
   output logic                  r_or_i,
   output logic                  is_load,
   output logic                  is_store,
   output logic                  illegal
);

   localparam logic [3:0] c_STALL_CNT = 4'(MEM_STALL);

   state_t                r_state;
   logic [3:0]            r_stall_cnt;
   logic                  r_out_valid;
   logic [7:0]            r_op;
   logic [3:0]            r_dest_q;
   logic [3:0]            r_src_q;
   logic [DATA_WIDTH-1:0] r_imm;
   logic                  r_r_or_i;
   logic                  r_is_load;
   logic                  r_is_store;
   logic                  r_illegal;

   logic [7:0]            w_op;
   logic [3:0]            w_dest;
   logic [3:0]            w_src;
   logic [DATA_WIDTH-1:0] w_imm;
   logic                  w_r_or_i;
   logic                  w_is_load;
   logic                  w_is_store;
   logic                  w_illegal;
   logic                  w_ready_st;
   logic                  w_in_fire;
   logic                  w_out_fire;
   logic                  w_held_mem;

   instr_decode_comb #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_decode (
      .i_instr    (in_instr),
      .o_op       (w_op),
      .o_r_dest   (w_dest),
      .o_r_src    (w_src),
      .o_imm      (w_imm),
      .o_r_or_i   (w_r_or_i),
      .o_is_load  (w_is_load),
      .o_is_store (w_is_store),
      .o_illegal  (w_illegal)
   );

   assign w_held_mem = r_is_load | r_is_store;

   // A held LOAD/STORE blocks new input even when it is being consumed,
   // so the stall window always follows it.
   always_comb begin
      w_ready_st = 1'b0;
      case (r_state)
         EMPTY:   w_ready_st = 1'b1;
         FULL:    w_ready_st = out_ready & ~w_held_mem;
         default: w_ready_st = 1'b0;
      endcase
   end

   // Gating with reset_n keeps in_ready low for the whole reset pulse.
   assign in_ready   = w_ready_st & reset_n;
   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = r_out_valid & out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= EMPTY;
         r_stall_cnt <= 4'h0;
         r_out_valid <= 1'b0;
         r_op        <= 8'h00;
         r_dest_q    <= 4'h0;
         r_src_q     <= 4'h0;
         r_imm       <= '0;
         r_r_or_i    <= 1'b1;
         r_is_load   <= 1'b0;
         r_is_store  <= 1'b0;
         r_illegal   <= 1'b0;
      end else begin
         if (w_in_fire) begin
            r_op       <= w_op;
            r_dest_q   <= w_dest;
            r_src_q    <= w_src;
            r_imm      <= w_imm;
            r_r_or_i   <= w_r_or_i;
            r_is_load  <= w_is_load;
            r_is_store <= w_is_store;
            r_illegal  <= w_illegal;
         end

         case (r_state)
            EMPTY: begin
               if (w_in_fire) begin
                  r_state     <= FULL;
                  r_out_valid <= 1'b1;
               end
            end
            FULL: begin
               if (w_out_fire && !w_in_fire) begin
                  r_out_valid <= 1'b0;
                  if (w_held_mem && (c_STALL_CNT != 4'h0)) begin
                     r_state     <= STALL;
                     r_stall_cnt <= c_STALL_CNT;
                  end else begin
                     r_state <= EMPTY;
                  end
               end
            end
            STALL: begin
               if (r_stall_cnt <= 4'h1) begin
                  r_state     <= EMPTY;
                  r_stall_cnt <= 4'h0;
               end else begin
                  r_stall_cnt <= r_stall_cnt - 4'h1;
               end
            end
            default: begin
               r_state     <= EMPTY;
               r_out_valid <= 1'b0;
               r_stall_cnt <= 4'h0;
            end
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign op        = r_op;
   assign r_dest    = r_dest_q;
   assign r_src     = r_src_q;
   assign imm       = r_imm;
   assign r_or_i    = r_r_or_i;
   assign is_load   = r_is_load;
   assign is_store  = r_is_store;
   assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_decode_stage
// Description : Self-checking bench for instr_decode_stage (MEM_STALL=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_decode_stage;

   localparam int DW = 16;
   localparam int MS = 2;
   localparam int NV = 17;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [15:0]   in_instr = 16'h0000;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic          in_ready;
   logic          out_valid;
   logic [7:0]    op;
   logic [3:0]    r_dest;
   logic [3:0]    r_src;
   logic [DW-1:0] imm;
   logic          r_or_i;
   logic          is_load;
   logic          is_store;
   logic          illegal;

   always #5 clk = ~clk;

   instr_decode_stage #(
      .DATA_WIDTH (DW),
      .MEM_STALL  (MS)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_instr  (in_instr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .op        (op),
      .r_dest    (r_dest),
      .r_src     (r_src),
      .imm       (imm),
      .r_or_i    (r_or_i),
      .is_load   (is_load),
      .is_store  (is_store),
      .illegal   (illegal)
   );

   typedef struct {
      logic [15:0] instr;
      logic [7:0]  op;
      logic [3:0]  rd;
      logic [3:0]  rs;
      logic [15:0] imm;
      logic        roi;
      logic        ld;
      logic        st;
      logic        ill;
   } vec_t;

   vec_t tbl [NV];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_bundle(input string tag, input vec_t e);
      chk({tag, ".op"},       32'(op),       32'(e.op));
      chk({tag, ".r_dest"},   32'(r_dest),   32'(e.rd));
      chk({tag, ".r_src"},    32'(r_src),    32'(e.rs));
      chk({tag, ".imm"},      32'(imm),      32'(e.imm));
      chk({tag, ".r_or_i"},   32'(r_or_i),   32'(e.roi));
      chk({tag, ".is_load"},  32'(is_load),  32'(e.ld));
      chk({tag, ".is_store"}, 32'(is_store), 32'(e.st));
      chk({tag, ".illegal"},  32'(illegal),  32'(e.ill));
   endtask

   // Reference decode straight from the instruction-class rules.
   function automatic vec_t ref_decode(input logic [15:0] x);
      vec_t r;
      int   hi;
      int   ext;
      int   b;
      hi  = int'(x[15:12]);
      ext = int'(x[7:4]);
      b   = int'(x[7:0]);
      r.instr = x;
      r.op    = {x[15:12], x[7:4]};
      r.rd    = x[11:8];
      r.rs    = x[3:0];
      r.imm   = 16'h0000;
      r.roi   = 1'b1;
      r.ld    = 1'b0;
      r.st    = 1'b0;
      r.ill   = 1'b0;
      if (hi == 0) begin
         r.ill = !(ext inside {0, 1, 2, 3, 5, 6, 7, 9, 10, 11, 13});
      end else if (hi == 8) begin
         if (ext <= 1) begin
            r.rs  = 4'h0;
            r.roi = 1'b0;
            r.imm = 16'((ext % 2) * 16 + int'(x[3:0]));
         end else if (ext != 4 && ext != 6) begin
            r.ill = 1'b1;
         end
      end else if (hi == 4) begin
         r.ld  = (ext == 0);
         r.st  = (ext == 4);
         r.ill = !(ext == 0 || ext == 4 || ext == 15);
      end else if (hi inside {1, 2, 3, 5, 9, 11, 13, 15}) begin
         r.op  = {x[15:12], 4'h0};
         r.rs  = 4'h0;
         r.roi = 1'b0;
         if (hi <= 3)       r.imm = 16'(b);
         else if (hi == 15) r.imm = 16'(b * 256);
         else               r.imm = 16'((b >= 128) ? b - 256 : b);
      end else begin
         r.ill = 1'b1;
      end
      return r;
   endfunction

   // Ends on a negedge where in_ready is high; an expired budget is a failure.
   task automatic wait_ready(input string tag);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) return;
      end
      n_checks++;
      n_errors++;
      $display("FAIL %s: in_ready got 0 expected 1 within 20 cycles", tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t   m_exp;
      logic   m_full;
      logic [15:0] m_instr;
      int     m_stall;
      logic   exp_rdy;
      logic   m_mem;
      logic [31:0] rv;
      int     sel;

      //            instr     op     rd    rs    imm       roi   ld    st    ill
      tbl[0]  = '{16'h0152, 8'h05, 4'h1, 4'h2, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{16'h53F0, 8'h50, 4'h3, 4'h0, 16'hFFF0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{16'h13F0, 8'h10, 4'h3, 4'h0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{16'hF312, 8'hF0, 4'h3, 4'h0, 16'h1200, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{16'h01E2, 8'h0E, 4'h1, 4'h2, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[5]  = '{16'h8315, 8'h81, 4'h3, 4'h0, 16'h0015, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{16'h8342, 8'h84, 4'h3, 4'h2, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{16'h43F2, 8'h4F, 4'h3, 4'h2, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{16'h4342, 8'h44, 4'h3, 4'h2, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[9]  = '{16'h4301, 8'h40, 4'h3, 4'h1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{16'hD280, 8'hD0, 4'h2, 4'h0, 16'hFF80, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{16'h6123, 8'h62, 4'h1, 4'h3, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[12] = '{16'h8371, 8'h87, 4'h3, 4'h1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[13] = '{16'hF380, 8'hF0, 4'h3, 4'h0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{16'h0000, 8'h00, 4'h0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{16'h4312, 8'h41, 4'h3, 4'h2, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[16] = '{16'h8306, 8'h80, 4'h3, 4'h0, 16'h0006, 1'b0, 1'b0, 1'b0, 1'b0};

      // ---------------- reset state ----------------
      #12;
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.in_ready",  32'(in_ready),  32'd0);
      chk_bundle("rst", '{16'h0000, 8'h00, 4'h0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_rst.in_ready",  32'(in_ready),  32'd1);
      chk("post_rst.out_valid", 32'(out_valid), 32'd0);

      // ---------------- decode table ----------------
      for (int i = 0; i < NV; i++) begin
         wait_ready($sformatf("vec%0d.wait", i));
         in_valid  = 1'b1;
         in_instr  = tbl[i].instr;
         out_ready = 1'b0;
         @(negedge clk);
         in_valid = 1'b0;
         chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'd1);
         chk_bundle($sformatf("vec%0d", i), tbl[i]);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         chk($sformatf("vec%0d.drained", i), 32'(out_valid), 32'd0);
      end

      // ---------------- backpressure ----------------
      wait_ready("bp.wait");
      in_valid  = 1'b1;
      in_instr  = 16'h0152;
      out_ready = 1'b0;
      @(negedge clk);
      in_instr = 16'h53F0;
      for (int c = 0; c < 3; c++) begin
         chk("bp.in_ready",  32'(in_ready),  32'd0);
         chk("bp.out_valid", 32'(out_valid), 32'd1);
         chk("bp.op",        32'(op),        32'h05);
         chk("bp.imm",       32'(imm),       32'h0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      chk("bp.release_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp.swap_valid", 32'(out_valid), 32'd1);
      chk("bp.swap_op",    32'(op),        32'h50);
      chk("bp.swap_imm",   32'(imm),       32'hFFF0);
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp.empty", 32'(out_valid), 32'd0);

      // ---------------- LOAD stall window ----------------
      wait_ready("ld.wait");
      in_valid  = 1'b1;
      in_instr  = 16'h4301;
      out_ready = 1'b1;
      @(negedge clk);
      in_instr = 16'h0152;
      chk("ld.c1.in_ready",  32'(in_ready),  32'd0);
      chk("ld.c1.out_valid", 32'(out_valid), 32'd1);
      chk("ld.c1.is_load",   32'(is_load),   32'd1);
      @(negedge clk);
      chk("ld.c2.in_ready",  32'(in_ready),  32'd0);
      chk("ld.c2.out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("ld.c3.in_ready",  32'(in_ready),  32'd0);
      @(negedge clk);
      chk("ld.c4.in_ready",  32'(in_ready),  32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("ld.next.out_valid", 32'(out_valid), 32'd1);
      chk("ld.next.op",        32'(op),        32'h05);
      chk("ld.next.is_load",   32'(is_load),   32'd0);
      @(negedge clk);
      out_ready = 1'b0;

      // ---------------- async reset mid-STALL ----------------
      wait_ready("ar.wait");
      in_valid  = 1'b1;
      in_instr  = 16'h4342;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("ar.stall.out_valid", 32'(out_valid), 32'd0);
      chk("ar.stall.is_store",  32'(is_store),  32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("ar.out_valid", 32'(out_valid), 32'd0);
      chk("ar.in_ready",  32'(in_ready),  32'd0);
      chk_bundle("ar", '{16'h0000, 8'h00, 4'h0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      reset_n   = 1'b1;
      out_ready = 1'b0;
      #1;
      chk("ar.rel.in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_instr = 16'h0152;
      @(negedge clk);
      in_valid = 1'b0;
      chk("ar.rel.out_valid", 32'(out_valid), 32'd1);
      chk("ar.rel.op",        32'(op),        32'h05);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // ---------------- randomized run against the model ----------------
      m_full  = 1'b0;
      m_instr = 16'h0000;
      m_stall = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         sel = int'($urandom_range(0, 9));
         rv  = $urandom();
         if (sel < 3)
            in_instr = {4'h4, rv[11:8], (sel == 0) ? 4'h4 : 4'h0, rv[3:0]};
         else
            in_instr = rv[15:0];
         #1;
         m_mem   = m_full && (ref_decode(m_instr).ld || ref_decode(m_instr).st);
         exp_rdy = (!m_full && m_stall == 0) || (m_full && out_ready && !m_mem);
         chk($sformatf("rnd%0d.in_ready", cyc),  32'(in_ready),  32'(exp_rdy));
         chk($sformatf("rnd%0d.out_valid", cyc), 32'(out_valid), 32'(m_full));
         if (m_full) begin
            m_exp = ref_decode(m_instr);
            chk_bundle($sformatf("rnd%0d", cyc), m_exp);
         end
         // Occupancy model: one slot, then MS idle cycles after a memory op leaves.
         if (m_stall > 0) begin
            m_stall--;
         end else if (in_valid && exp_rdy) begin
            m_full  = 1'b1;
            m_instr = in_instr;
         end else if (m_full && out_ready) begin
            m_full = 1'b0;
            if (m_mem) m_stall = MS;
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
